// File: rtl/andgate_checker.sv
// Checks an upstream AND-gate stage over CHECK_LEN registered samples.
// The LED is steady for pass and blinks from a cleared divider for fail.
module andgate_checker #(
  parameter int CHECK_LEN = 16,
  parameter int BLINK_W   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  input  logic       start,
  output logic       led,
  output logic       led_oe,
  output logic       pass,
  output logic       fail,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  state_t             r_state;
  logic               r_a_q;
  logic               r_b_q;
  logic               r_y_q;
  logic               r_arm;
  logic [15:0]        r_sample;
  logic [BLINK_W-1:0] r_div;
  logic [7:0]         r_err;
  logic               r_led;
  logic               r_led_oe;
  logic               r_pass;
  logic               r_fail;

  logic               w_mis;
  logic               w_last;
  logic               w_start;
  logic [BLINK_W-1:0] w_div_inc;

  assign w_mis     = r_y_q ^ (r_a_q & r_b_q);
  assign w_last    = (r_sample == 16'(CHECK_LEN - 1));
  assign w_div_inc = r_div + 1'b1;
  // r_arm is low on the edge that releases reset, so a start pulse that
  // coincides with the release is never accepted.
  assign w_start   = start & r_arm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_a_q    <= 1'b0;
      r_b_q    <= 1'b0;
      r_y_q    <= 1'b0;
      r_arm    <= 1'b0;
      r_sample <= '0;
      r_div    <= '0;
      r_err    <= '0;
      r_led    <= 1'b0;
      r_led_oe <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_a_q <= a;
      r_b_q <= b;
      r_y_q <= y;
      r_arm <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_CHECK;
            r_err    <= '0;
            r_sample <= '0;
          end
        end
        S_CHECK: begin
          r_sample <= r_sample + 16'd1;
          if (w_mis && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
          end
          // The verdict includes the mismatch of this final compare.
          if (w_last) begin
            r_led_oe <= 1'b1;
            if ((r_err == 8'd0) && !w_mis) begin
              r_state <= S_PASS;
              r_pass  <= 1'b1;
              r_led   <= 1'b1;
            end else begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
              r_led   <= 1'b0;
              r_div   <= '0;
            end
          end
        end
        S_PASS: begin
          if (w_start) begin
            r_state  <= S_CHECK;
            r_err    <= '0;
            r_sample <= '0;
            r_pass   <= 1'b0;
            r_led    <= 1'b0;
            r_led_oe <= 1'b0;
          end
        end
        S_FAIL: begin
          if (w_start) begin
            r_state  <= S_CHECK;
            r_err    <= '0;
            r_sample <= '0;
            r_fail   <= 1'b0;
            r_led    <= 1'b0;
            r_led_oe <= 1'b0;
          end else begin
            r_div <= w_div_inc;
            r_led <= w_div_inc[BLINK_W-1];
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign led     = r_led;
  assign led_oe  = r_led_oe;
  assign pass    = r_pass;
  assign fail    = r_fail;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_andgate_checker.sv
// Directed bench for andgate_checker: a CHECK_LEN=4/BLINK_W=3 instance for
// run, blink, restart and reset cases, and a CHECK_LEN=300 one for saturation.
module tb_andgate_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic       b;
  logic       y;
  logic       start;
  logic       start_s;
  logic       led;
  logic       led_oe;
  logic       pass;
  logic       fail;
  logic [7:0] err_cnt;
  logic       led_s;
  logic       led_oe_s;
  logic       pass_s;
  logic       fail_s;
  logic [7:0] err_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  andgate_checker #(.CHECK_LEN(4), .BLINK_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .y       (y),
    .start   (start),
    .led     (led),
    .led_oe  (led_oe),
    .pass    (pass),
    .fail    (fail),
    .err_cnt (err_cnt)
  );

  andgate_checker #(.CHECK_LEN(300), .BLINK_W(3)) dut_s (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .y       (y),
    .start   (start_s),
    .led     (led_s),
    .led_oe  (led_oe_s),
    .pass    (pass_s),
    .fail    (fail_s),
    .err_cnt (err_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0d t=%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ia, input logic ib, input logic iy, input logic ist);
    a     = ia;
    b     = ib;
    y     = iy;
    start = ist;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_led_oe"}, 32'(led_oe), 32'd0);
    chk({tag, "_led"},    32'(led),    32'd0);
    chk({tag, "_pass"},   32'(pass),   32'd0);
    chk({tag, "_fail"},   32'(fail),   32'd0);
    chk({tag, "_err"},    32'(err_cnt), 32'd0);
  endtask

  initial begin
    // Reset with random inputs, checked before any clock edge.
    reset   = 1'b0;
    start_s = 1'b0;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #2;
    chk_idle("rst_async");
    chk("rst_async_pass_s", 32'(pass_s), 32'd0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();

    // Clean run: 00/0, 01/0, 10/0, 11/1.
    drive(0, 0, 0, 1);
    tick();
    chk("clean_check_oe", 32'(led_oe), 32'd0);
    drive(0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 1, 0);
    tick();
    chk("clean_c3_pass", 32'(pass), 32'd0);
    drive(0, 0, 0, 0);
    tick();
    chk("clean_pass",   32'(pass),    32'd1);
    chk("clean_fail",   32'(fail),    32'd0);
    chk("clean_err",    32'(err_cnt), 32'd0);
    chk("clean_led_oe", 32'(led_oe),  32'd1);
    chk("clean_led",    32'(led),     32'd1);
    repeat (3) tick();
    chk("clean_hold_pass", 32'(pass), 32'd1);
    chk("clean_hold_led",  32'(led),  32'd1);

    // Fault run from PASS: two compares with a=b=0, y=1.
    drive(0, 0, 1, 1);
    tick();
    chk("fault_check_pass", 32'(pass),   32'd0);
    chk("fault_check_oe",   32'(led_oe), 32'd0);
    drive(0, 0, 1, 0);
    tick();
    drive(1, 1, 1, 0);
    tick();
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("fault_fail",   32'(fail),    32'd1);
    chk("fault_pass",   32'(pass),    32'd0);
    chk("fault_err",    32'(err_cnt), 32'd2);
    chk("fault_led_oe", 32'(led_oe),  32'd1);
    chk("fault_led0",   32'(led),     32'd0);
    repeat (3) tick();
    chk("blink_3",  32'(led), 32'd0);
    tick();
    chk("blink_4",  32'(led), 32'd1);
    repeat (3) tick();
    chk("blink_7",  32'(led), 32'd1);
    tick();
    chk("blink_8",  32'(led), 32'd0);
    chk("fault_err_hold", 32'(err_cnt), 32'd2);

    // Restart from FAIL, then a start pulse mid-CHECK that must be ignored.
    drive(0, 0, 0, 1);
    tick();
    chk("restart_fail",   32'(fail),    32'd0);
    chk("restart_err",    32'(err_cnt), 32'd0);
    chk("restart_led_oe", 32'(led_oe),  32'd0);
    drive(0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("midstart_c3_pass", 32'(pass), 32'd0);
    tick();
    chk("midstart_pass", 32'(pass),    32'd1);
    chk("midstart_err",  32'(err_cnt), 32'd0);

    // Reset asserted during compare 2 of a faulty run.
    drive(0, 0, 1, 1);
    tick();
    drive(0, 0, 1, 0);
    tick();
    chk("midrst_err_before", 32'(err_cnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (6) tick();
    chk_idle("midrst_after");

    // Start coincident with the reset-release edge is ignored.
    reset = 1'b0;
    drive(0, 0, 0, 1);
    @(posedge clk);
    reset = 1'b1;
    #1;
    start = 1'b0;
    chk("relstart_oe", 32'(led_oe), 32'd0);
    repeat (6) tick();
    chk("relstart_pass", 32'(pass), 32'd0);
    chk("relstart_fail", 32'(fail), 32'd0);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    repeat (4) tick();
    chk("newstart_pass", 32'(pass), 32'd1);

    // Saturation: y = ~(a & b) for all 300 compares.
    a       = 1'b1;
    b       = 1'b1;
    y       = 1'b0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) chk("sat_254", 32'(err_cnt_s), 32'd254);
      if (i == 256) chk("sat_256", 32'(err_cnt_s), 32'd255);
      if (i == 299) chk("sat_299_fail", 32'(fail_s), 32'd0);
    end
    chk("sat_fail",   32'(fail_s),    32'd1);
    chk("sat_pass",   32'(pass_s),    32'd0);
    chk("sat_err",    32'(err_cnt_s), 32'd255);
    chk("sat_led_oe", 32'(led_oe_s),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
